alu_issue: RTL and testbench
============================

# alu_issue

Initiator side of the ALU interface. Accepts one RV32I integer-ALU instruction at a time, decodes it, reads operands from an internal 32×32 register file, drives the `alu` port set (`instr`, `op1`, `op2`, `pc`, `enable`), waits the ALU latency, captures `result` and writes it back to `rd`. It sits between the fetch stage and the existing `alu` block and replaces the bench-driven stimulus with real operand generation.

## Interface
- `ALU_LATENCY`, default 2: edges between the edge that samples `alu_enable` and the edge at which `alu_result` is valid. Legal range 1..15.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `instr_valid`  in  1  upstream has an instruction.
- `instr_ready`  out  1  block can accept; high only in IDLE.
- `instr_in`  in  32  `instruction_t` from the `opcodes` package.
- `pc_in`  in  32  `register_t`, PC of `instr_in`.
- `alu_instr`  out  32  instruction presented to the ALU.
- `alu_op1`, `alu_op2`  out  32 each  operands presented to the ALU.
- `alu_pc`  out  32  PC presented to the ALU.
- `alu_enable`  out  1  one-cycle start strobe.
- `alu_result`  in  32  ALU result.
- `wb_valid`  out  1  one-cycle writeback pulse.
- `wb_rd`  out  5  destination register.
- `wb_data`  out  32  written value.
- `illegal`  out  1  one-cycle pulse for an undecodable instruction.
- `dbg_addr`  in  5  debug read address.
- `dbg_data`  out  32  combinational register-file read; x0 always reads 0.

## Operation
- FSM states: IDLE → ISSUE → WAIT → WRITE → IDLE.
- IDLE: `instr_ready`=1. When `instr_valid` is high, latch `instr_in` and `pc_in`, then decode.
  - Illegal instruction: pulse `illegal` in the next cycle and stay in IDLE.
  - Otherwise go to ISSUE.
- Legal instructions:
  - opcode 0110011 (R-type), with funct7 = 0000000, or funct7 = 0100000 only for funct3 = 000 (SUB) or 101 (SRA).
  - opcode 0010011 (I-type). For SLLI, funct7 must be 0000000. For SRLI/SRAI, funct7 must be 0000000 or 0100000.
  - opcode 0110111 (LUI) and 0010111 (AUIPC).
  - Everything else is illegal.
- Operand generation:
  - R-type: op1 = x[rs1], op2 = x[rs2].
  - I-type arithmetic/logic: op1 = x[rs1], op2 = sign-extended instr[31:20].
  - I-type shifts: op2 = {27'b0, instr[24:20]}.
  - LUI and AUIPC: op1 = {instr[31:12], 12'b0}, op2 = 0.
  - `alu_pc` = latched PC for AUIPC, 0 otherwise.
  - `alu_instr` = latched instruction, unmodified.
- ISSUE: `alu_enable`=1 for exactly this cycle. Operands are read from the register file in this cycle.
- WAIT: lasts ALU_LATENCY cycles. `alu_enable`=0. `alu_instr`, `alu_op1`, `alu_op2` and `alu_pc` stay stable.
- WRITE: `wb_valid`=1 and `wb_data`=`alu_result`. At the end of the cycle, write x[rd] unless rd = 0; x0 is never written. `wb_rd`/`wb_data` still show rd = 0 with `wb_valid` high.
- Register file: all 32 entries are cleared to 0 on reset. The write in WRITE is visible to the next instruction's ISSUE read, so back-to-back dependencies need no forwarding.

## Timing
- Reset values: state IDLE, `instr_ready`=1, every other output 0 (`alu_*`, `wb_*`, `illegal`, `dbg_data` for the cleared registers).
- Accept at edge E: ISSUE occupies cycle E..E+1 and `alu_enable` is sampled at E+1.
- WAIT occupies ALU_LATENCY cycles. WRITE is the cycle after WAIT.
- Initiation interval: ALU_LATENCY+3 cycles. With ALU_LATENCY=2, `wb_valid` is high 4 cycles after acceptance and a new instruction is accepted every 5 cycles.
- `instr_ready` is low from ISSUE through WRITE. `instr_valid` in those cycles is ignored, and upstream must hold it.
- Illegal instruction: `illegal` is high in cycle E..E+1 and `instr_ready` stays high, so the next instruction can be accepted at E+1.
- `rst` asserted in any state: next state IDLE, all outputs at reset values, register file cleared, any in-flight writeback dropped (no `wb_valid`).

## Test plan
- Immediate and forwarding: ADDI x1,x0,-3 then ADD x3,x1,x1 → `wb_data`=FFFFFFFD for x1, then FFFFFFFA for x3. `alu_enable` is a single cycle and `wb_valid` follows it after ALU_LATENCY+1 cycles.
- Arithmetic shift: x2=F0F0F0F0 (LUI F0F0F plus ORI), then SRAI x4,x2,4 → FF0F0F0F, and SRLI x5,x2,4 → 0F0F0F0F. Check `alu_op2`=00000004.
- Upper immediates: LUI x6,0x12345 → 12345000. AUIPC x7,0x1 with pc_in=00001000 → `alu_op1`=00001000, `alu_pc`=00001000, result 00002000.
- x0 protection: ADDI x0,x0,5 → `wb_valid` pulses with `wb_rd`=0, and `dbg_data` for x0 stays 0.
- Illegal instructions: load opcode 0000011, and R-type with funct7=0100000 and funct3=111 → `illegal` pulses once each, no `alu_enable`, no `wb_valid`, register file unchanged.
- Reset mid-operation: assert `rst` during WAIT → `wb_valid` never rises, all `dbg_data` reads 0, `instr_ready`=1 the cycle after reset.

Source files
------------

// File: rtl/alu_issue.sv
// alu_issue: initiator side of the ALU interface.
// Takes one RV32I integer-ALU instruction at a time from fetch, decodes it,
// reads operands from a local 32x32 register file, starts the external ALU,
// waits ALU_LATENCY cycles, then writes the result back to rd.
//
// Handshake: instr_valid/instr_ready is a strict valid/ready pair; a transfer
// happens on a rising edge where both are high. instr_ready is high only in
// IDLE, so upstream must hold instr_valid and instr_in stable while ready is low.
module alu_issue #(
  parameter int ALU_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_in,
  output logic [31:0] alu_instr,
  output logic [31:0] alu_op1,
  output logic [31:0] alu_op2,
  output logic [31:0] alu_pc,
  output logic        alu_enable,
  input  logic [31:0] alu_result,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        illegal,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] WRITE = 2'd3;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  // Last value of the WAIT counter before moving to WRITE.
  localparam logic [3:0] WAIT_LAST = 4'(ALU_LATENCY - 1);

  logic [1:0]  state;
  logic [3:0]  wait_cnt;
  logic [31:0] instr_q;
  logic [31:0] pc_q;
  logic [31:0] op1_q;
  logic [31:0] op2_q;
  logic [31:0] alu_instr_q;
  logic [31:0] alu_pc_q;
  logic        illegal_q;
  logic [31:0] rf [32];

  logic        in_legal;
  logic [31:0] iss_op1;
  logic [31:0] iss_op2;
  logic [31:0] iss_pc;

  // Legality of the instruction currently offered on instr_in.
  always_comb begin
    in_legal = 1'b0;
    case (instr_in[6:0])
      OPC_OP: begin
        if (instr_in[31:25] == 7'b0000000)
          in_legal = 1'b1;
        else if (instr_in[31:25] == 7'b0100000 &&
                 (instr_in[14:12] == 3'b000 || instr_in[14:12] == 3'b101))
          in_legal = 1'b1;
      end
      OPC_IMM: begin
        if (instr_in[14:12] == 3'b001)
          in_legal = (instr_in[31:25] == 7'b0000000);
        else if (instr_in[14:12] == 3'b101)
          in_legal = (instr_in[31:25] == 7'b0000000) ||
                     (instr_in[31:25] == 7'b0100000);
        else
          in_legal = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: in_legal = 1'b1;
      default: in_legal = 1'b0;
    endcase
  end

  // Operand generation from the latched instruction; register reads happen
  // in ISSUE, after any preceding WRITE has landed, so no forwarding is needed.
  always_comb begin
    iss_op1 = rf[instr_q[19:15]];
    iss_op2 = rf[instr_q[24:20]];
    iss_pc  = 32'd0;
    case (instr_q[6:0])
      OPC_IMM: begin
        if (instr_q[14:12] == 3'b001 || instr_q[14:12] == 3'b101)
          iss_op2 = {27'd0, instr_q[24:20]};
        else
          iss_op2 = {{20{instr_q[31]}}, instr_q[31:20]};
      end
      OPC_LUI: begin
        iss_op1 = {instr_q[31:12], 12'd0};
        iss_op2 = 32'd0;
      end
      OPC_AUIPC: begin
        iss_op1 = {instr_q[31:12], 12'd0};
        iss_op2 = 32'd0;
        iss_pc  = pc_q;
      end
      default: ;
    endcase
  end

  // Port drive: live operands during ISSUE, held copies afterwards so the
  // ALU sees stable inputs for the whole WAIT/WRITE window.
  always_comb begin
    instr_ready = (state == IDLE);
    alu_enable  = (state == ISSUE);
    alu_instr   = (state == ISSUE) ? instr_q : alu_instr_q;
    alu_op1     = (state == ISSUE) ? iss_op1 : op1_q;
    alu_op2     = (state == ISSUE) ? iss_op2 : op2_q;
    alu_pc      = (state == ISSUE) ? iss_pc  : alu_pc_q;
    wb_valid    = (state == WRITE);
    wb_rd       = (state == WRITE) ? instr_q[11:7] : 5'd0;
    wb_data     = (state == WRITE) ? alu_result : 32'd0;
    illegal     = illegal_q;
    dbg_data    = rf[dbg_addr];
    dbg_state   = state;
  end

  // Control FSM and the latched instruction / operand copies.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wait_cnt    <= 4'd0;
      instr_q     <= 32'd0;
      pc_q        <= 32'd0;
      op1_q       <= 32'd0;
      op2_q       <= 32'd0;
      alu_instr_q <= 32'd0;
      alu_pc_q    <= 32'd0;
      illegal_q   <= 1'b0;
    end else begin
      illegal_q <= 1'b0;
      case (state)
        IDLE: begin
          if (instr_valid) begin
            instr_q <= instr_in;
            pc_q    <= pc_in;
            if (in_legal)
              state <= ISSUE;
            else
              illegal_q <= 1'b1;
          end
        end
        ISSUE: begin
          op1_q       <= iss_op1;
          op2_q       <= iss_op2;
          alu_instr_q <= instr_q;
          alu_pc_q    <= iss_pc;
          wait_cnt    <= 4'd0;
          state       <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == WAIT_LAST)
            state <= WRITE;
          else
            wait_cnt <= wait_cnt + 4'd1;
        end
        WRITE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Register file: cleared on reset, written at the end of WRITE; x0 never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
    end else if (state == WRITE && instr_q[11:7] != 5'd0) begin
      rf[instr_q[11:7]] <= alu_result;
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: self-checking bench for alu_issue with a behavioural ALU.
module tb_alu_issue;

  localparam int L = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] instr_in = 32'd0;
  logic [31:0] pc_in = 32'd0;
  logic [31:0] alu_instr, alu_op1, alu_op2, alu_pc;
  logic        alu_enable;
  logic [31:0] alu_result = 32'hDEADBEEF;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        illegal;
  logic [4:0]  dbg_addr = 5'd0;
  logic [31:0] dbg_data;
  logic [1:0]  dbg_state;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int en_cyc = -100;
  int en_count = 0;
  int wb_count = 0;
  int ill_count = 0;
  logic        busy_chk = 1'b0;
  logic [31:0] cap_op1, cap_op2;

  logic [31:0] shadow [32];
  logic [36:0] exp_q[$];

  alu_issue #(.ALU_LATENCY(L)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_in(instr_in), .pc_in(pc_in),
    .alu_instr(alu_instr), .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_pc(alu_pc),
    .alu_enable(alu_enable), .alu_result(alu_result),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .illegal(illegal), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- encoders / reference ----------------
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rd, opc};
  endfunction

  function automatic logic [31:0] alu_core(input logic [2:0] f3, input logic alt,
                                           input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    sa = a;
    case (f3)
      3'd0: return alt ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return {31'd0, ($signed(a) < $signed(b))};
      3'd3: return {31'd0, (a < b)};
      3'd4: return a ^ b;
      3'd5: return alt ? 32'(sa >>> b[4:0]) : a >> b[4:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  // External ALU behaviour, driven only from the DUT's alu_* ports.
  function automatic logic [31:0] model_exec(input logic [31:0] ins, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] pc);
    case (ins[6:0])
      7'b0110011: return alu_core(ins[14:12], ins[30], a, b);
      7'b0010011: return alu_core(ins[14:12], (ins[14:12] == 3'd5) & ins[30], a, b);
      7'b0110111: return a;
      7'b0010111: return a + pc;
      default:    return 32'hBAD0BAD0;
    endcase
  endfunction

  // Architectural reference: executes the instruction against the shadow file.
  function automatic logic [36:0] ref_exec(input logic [31:0] ins, input logic [31:0] pc);
    logic [31:0] r;
    logic [31:0] imm;
    imm = {{20{ins[31]}}, ins[31:20]};
    case (ins[6:0])
      7'b0110011: r = alu_core(ins[14:12], ins[30], shadow[ins[19:15]], shadow[ins[24:20]]);
      7'b0010011: r = alu_core(ins[14:12], (ins[14:12] == 3'd5) & ins[30], shadow[ins[19:15]], imm);
      7'b0110111: r = {ins[31:12], 12'd0};
      default:    r = pc + {ins[31:12], 12'd0};
    endcase
    if (ins[11:7] != 5'd0) shadow[ins[11:7]] = r;
    return {ins[11:7], r};
  endfunction

  // ---------------- ALU model (latency L) ----------------
  int acnt = 0;
  logic [31:0] a_next;
  always @(negedge clk) begin
    if (rst) begin
      acnt = 0;
      alu_result = 32'hDEADBEEF;
    end else if (alu_enable) begin
      a_next = model_exec(alu_instr, alu_op1, alu_op2, alu_pc);
      acnt = L;
      alu_result = 32'hDEADBEEF;
    end else if (acnt > 0) begin
      acnt--;
      if (acnt == 0) alu_result = a_next;
    end
  end

  // ---------------- scoreboard / monitor ----------------
  always @(posedge clk) begin
    logic [36:0] e;
    cyc++;
    #1;
    if (!rst) begin
      if (alu_enable) begin
        tests++;
        if (en_cyc == cyc - 1) begin
          fails++;
          $display("FAIL enable_width: alu_enable high in consecutive cycles at cycle %0d", cyc);
        end
        en_cyc = cyc;
        en_count++;
        cap_op1 = alu_op1;
        cap_op2 = alu_op2;
        busy_chk = 1'b1;
      end else if (busy_chk) begin
        tests++;
        if (alu_op1 !== cap_op1 || alu_op2 !== cap_op2) begin
          fails++;
          $display("FAIL op_stable: op1=%h op2=%h, required %h %h", alu_op1, alu_op2, cap_op1, cap_op2);
        end
      end
      if (wb_valid) begin
        busy_chk = 1'b0;
        wb_count++;
        tests++;
        if (cyc - en_cyc != L + 1) begin
          fails++;
          $display("FAIL wb_latency: %0d cycles after enable, required %0d", cyc - en_cyc, L + 1);
        end
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL wb_unexpected: rd=%0d data=%h, required no writeback", wb_rd, wb_data);
        end else begin
          e = exp_q.pop_front();
          if ({wb_rd, wb_data} !== e) begin
            fails++;
            $display("FAIL wb_data: rd=%0d data=%h, required rd=%0d data=%h", wb_rd, wb_data, e[36:32], e[31:0]);
          end
        end
      end
      if (illegal) ill_count++;
    end else begin
      busy_chk = 1'b0;
    end
  end

  // ---------------- drivers ----------------
  // Presents one instruction and returns at posedge+1 after it was taken.
  task automatic send(input logic [31:0] ins, input logic [31:0] pc, input bit legal);
    int n;
    n = 0;
    while (instr_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) begin
      tests++; fails++;
      $display("FAIL send_timeout: instr_ready=%b, required 1", instr_ready);
    end else begin
      instr_valid = 1'b1;
      instr_in = ins;
      pc_in = pc;
      if (legal) exp_q.push_back(ref_exec(ins, pc));
      @(posedge clk); #1;
      instr_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || instr_ready !== 1'b1) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    tests++;
    if (n >= 100) begin
      fails++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 32; i++) shadow[i] = 32'd0;
    exp_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    tests++;
    if (instr_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: %b, required 1", instr_ready); end
    tests++;
    if ({alu_enable, wb_valid, illegal} !== 3'b000) begin
      fails++; $display("FAIL reset_strobes: en/wb/ill=%b%b%b, required 000", alu_enable, wb_valid, illegal);
    end
    tests++;
    if ({alu_instr, alu_op1, alu_op2, alu_pc} !== 128'd0) begin
      fails++; $display("FAIL reset_alu_ports: %h %h %h %h, required 0", alu_instr, alu_op1, alu_op2, alu_pc);
    end
    tests++;
    if ({wb_rd, wb_data} !== 37'd0) begin
      fails++; $display("FAIL reset_wb: rd=%0d data=%h, required 0", wb_rd, wb_data);
    end
    tests++;
    if (dbg_state !== 2'd0) begin fails++; $display("FAIL reset_state: %0d, required 0", dbg_state); end
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      @(negedge clk);
      tests++;
      if (dbg_data !== 32'd0) begin fails++; $display("FAIL reset_rf: x%0d=%h, required 0", i, dbg_data); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_imm_forward();
    int acc1, acc2;
    send(enc_i(12'hFFD, 5'd0, 3'd0, 5'd1), 32'd0, 1'b1);
    acc1 = cyc;
    tests++;
    if (alu_enable !== 1'b1 || instr_ready !== 1'b0) begin
      fails++; $display("FAIL issue_cycle: en=%b ready=%b, required 1 0", alu_enable, instr_ready);
    end
    @(posedge clk); #1;
    tests++;
    if (alu_enable !== 1'b0) begin fails++; $display("FAIL enable_single: %b, required 0", alu_enable); end
    send(enc_r(7'd0, 5'd1, 5'd1, 3'd0, 5'd3), 32'd0, 1'b1);
    acc2 = cyc;
    tests++;
    if (acc2 - acc1 != L + 3) begin
      fails++; $display("FAIL init_interval: %0d, required %0d", acc2 - acc1, L + 3);
    end
    drain();
    dbg_addr = 5'd1;
    @(negedge clk);
    tests++;
    if (dbg_data !== 32'hFFFFFFFD) begin fails++; $display("FAIL rf_x1: %h, required FFFFFFFD", dbg_data); end
    dbg_addr = 5'd3;
    @(negedge clk);
    tests++;
    if (dbg_data !== 32'hFFFFFFFA) begin fails++; $display("FAIL rf_x3: %h, required FFFFFFFA", dbg_data); end
    @(posedge clk); #1;
  endtask

  task automatic test_shift();
    send(enc_u(20'hF0F0F, 5'd2, 7'b0110111), 32'd0, 1'b1);
    send(enc_i(12'h0F0, 5'd2, 3'd6, 5'd2), 32'd0, 1'b1);
    send(enc_i({7'b0100000, 5'd4}, 5'd2, 3'd5, 5'd4), 32'd0, 1'b1);
    tests++;
    if (alu_op1 !== 32'hF0F0F0F0 || alu_op2 !== 32'h00000004) begin
      fails++; $display("FAIL srai_operands: op1=%h op2=%h, required F0F0F0F0 00000004", alu_op1, alu_op2);
    end
    send(enc_i({7'b0000000, 5'd4}, 5'd2, 3'd5, 5'd5), 32'd0, 1'b1);
    drain();
    dbg_addr = 5'd4;
    @(negedge clk);
    tests++;
    if (dbg_data !== 32'hFF0F0F0F) begin fails++; $display("FAIL rf_x4: %h, required FF0F0F0F", dbg_data); end
    dbg_addr = 5'd5;
    @(negedge clk);
    tests++;
    if (dbg_data !== 32'h0F0F0F0F) begin fails++; $display("FAIL rf_x5: %h, required 0F0F0F0F", dbg_data); end
    @(posedge clk); #1;
  endtask

  task automatic test_upper();
    send(enc_u(20'h12345, 5'd6, 7'b0110111), 32'h00000400, 1'b1);
    tests++;
    if (alu_op1 !== 32'h12345000 || alu_pc !== 32'd0) begin
      fails++; $display("FAIL lui_ports: op1=%h pc=%h, required 12345000 00000000", alu_op1, alu_pc);
    end
    send(enc_u(20'h00001, 5'd7, 7'b0010111), 32'h00001000, 1'b1);
    tests++;
    if (alu_op1 !== 32'h00001000 || alu_pc !== 32'h00001000 || alu_op2 !== 32'd0) begin
      fails++; $display("FAIL auipc_ports: op1=%h op2=%h pc=%h, required 00001000 0 00001000", alu_op1, alu_op2, alu_pc);
    end
    drain();
    dbg_addr = 5'd6;
    @(negedge clk);
    tests++;
    if (dbg_data !== 32'h12345000) begin fails++; $display("FAIL rf_x6: %h, required 12345000", dbg_data); end
    dbg_addr = 5'd7;
    @(negedge clk);
    tests++;
    if (dbg_data !== 32'h00002000) begin fails++; $display("FAIL rf_x7: %h, required 00002000", dbg_data); end
    @(posedge clk); #1;
  endtask

  task automatic test_x0();
    int w0;
    w0 = wb_count;
    send(enc_i(12'd5, 5'd0, 3'd0, 5'd0), 32'd0, 1'b1);
    drain();
    tests++;
    if (wb_count != w0 + 1) begin fails++; $display("FAIL x0_wb_pulse: %0d pulses, required 1", wb_count - w0); end
    dbg_addr = 5'd0;
    @(negedge clk);
    tests++;
    if (dbg_data !== 32'd0) begin fails++; $display("FAIL x0_read: %h, required 0", dbg_data); end
    @(posedge clk); #1;
  endtask

  task automatic test_illegal();
    int e0, w0, i0;
    e0 = en_count; w0 = wb_count; i0 = ill_count;
    send({12'd0, 5'd1, 3'b010, 5'd1, 7'b0000011}, 32'd0, 1'b0);
    tests++;
    if (illegal !== 1'b1 || instr_ready !== 1'b1) begin
      fails++; $display("FAIL illegal_load: ill=%b ready=%b, required 1 1", illegal, instr_ready);
    end
    send(enc_r(7'b0100000, 5'd1, 5'd1, 3'b111, 5'd3), 32'd0, 1'b0);
    tests++;
    if (illegal !== 1'b1 || alu_enable !== 1'b0) begin
      fails++; $display("FAIL illegal_rtype: ill=%b en=%b, required 1 0", illegal, alu_enable);
    end
    send(enc_i({7'b0100000, 5'd1}, 5'd2, 3'b001, 5'd4), 32'd0, 1'b0);
    tests++;
    if (illegal !== 1'b1) begin fails++; $display("FAIL illegal_slli: ill=%b, required 1", illegal); end
    @(posedge clk); #1;
    tests++;
    if (illegal !== 1'b0) begin fails++; $display("FAIL illegal_drop: ill=%b, required 0", illegal); end
    repeat (6) @(posedge clk);
    #1;
    tests++;
    if (en_count != e0 || wb_count != w0 || ill_count != i0 + 3) begin
      fails++; $display("FAIL illegal_counts: en=%0d wb=%0d ill=%0d, required 0 0 3",
                        en_count - e0, wb_count - w0, ill_count - i0);
    end
    for (int i = 1; i < 5; i++) begin
      dbg_addr = 5'(i);
      @(negedge clk);
      tests++;
      if (dbg_data !== shadow[i]) begin
        fails++; $display("FAIL illegal_rf: x%0d=%h, required %h", i, dbg_data, shadow[i]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [2:0]  f3;
    logic        alt;
    logic [4:0]  rs1, rs2, rd;
    logic [11:0] imm;
    for (int k = 0; k < 16; k++) begin
      f3  = 3'($urandom_range(0, 7));
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));
      rd  = 5'($urandom_range(0, 7));
      alt = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        if (f3 != 3'd0 && f3 != 3'd5) alt = 1'b0;
        send(enc_r(alt ? 7'b0100000 : 7'b0000000, rs2, rs1, f3, rd), 32'd0, 1'b1);
      end else begin
        imm = 12'($urandom_range(0, 4095));
        if (f3 == 3'd1) imm[11:5] = 7'd0;
        if (f3 == 3'd5) imm[11:5] = alt ? 7'b0100000 : 7'b0000000;
        send(enc_i(imm, rs1, f3, rd), 32'd0, 1'b1);
      end
    end
    drain();
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 5'(i);
      @(negedge clk);
      tests++;
      if (dbg_data !== shadow[i]) begin
        fails++; $display("FAIL b2b_rf: x%0d=%h, required %h", i, dbg_data, shadow[i]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int w0, n;
    send(enc_i(12'd77, 5'd0, 3'd0, 5'd9), 32'd0, 1'b1);
    n = 0;
    while (dbg_state !== 2'd2 && n < 20) begin @(posedge clk); #1; n++; end
    tests++;
    if (n >= 20) begin fails++; $display("FAIL reach_wait: state=%0d, required 2", dbg_state); end
    w0 = wb_count;
    rst = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 32; i++) shadow[i] = 32'd0;
    @(posedge clk); #1;
    rst = 1'b0;
    tests++;
    if (instr_ready !== 1'b1 || dbg_state !== 2'd0) begin
      fails++; $display("FAIL mid_reset_ready: ready=%b state=%0d, required 1 0", instr_ready, dbg_state);
    end
    repeat (8) @(posedge clk);
    #1;
    tests++;
    if (wb_count != w0) begin fails++; $display("FAIL mid_reset_wb: %0d pulses, required 0", wb_count - w0); end
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      @(negedge clk);
      tests++;
      if (dbg_data !== 32'd0) begin fails++; $display("FAIL mid_reset_rf: x%0d=%h, required 0", i, dbg_data); end
    end
    @(posedge clk); #1;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_imm_forward();
    test_shift();
    test_upper();
    test_x0();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
